// File: rtl/motor_pkg.sv
//------------------------------------------------------------------
// motor_pkg : shared opcodes, direction codes and steer time unit
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package motor_pkg;

  typedef enum logic [1:0] {
    OP_KEEPALIVE = 2'b00,
    OP_DRIVE     = 2'b01,
    OP_STEER     = 2'b10,
    OP_STOP      = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_STEER_BUSY = 1'b1
  } seq_state_e;

  localparam logic [1:0] DIR_COAST    = 2'b00;
  localparam logic [1:0] DIR_FORWARD  = 2'b10;
  localparam logic [1:0] DIR_BACKWARD = 2'b01;
  localparam logic [1:0] STEER_LEFT   = 2'b10;
  localparam logic [1:0] STEER_RIGHT  = 2'b01;

  // One steer_time unit is 2**STEER_UNIT_LOG2 = 128 clk cycles.
  localparam int STEER_UNIT_LOG2 = 7;
  localparam int STEER_TIME_W    = 21;

endpackage

`default_nettype wire

// File: rtl/duty_ramp.sv
//------------------------------------------------------------------
// duty_ramp : slew-limited duty with direction reversal through zero
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module duty_ramp
  import motor_pkg::*;
#(
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  input  logic [7:0] target,
  input  logic [1:0] req_dir,
  output logic [7:0] duty,
  output logic [1:0] dir,
  output logic       at_target
);

  localparam logic [7:0] STEP = 8'(RAMP_STEP);

  logic [7:0] duty_q, duty_d;
  logic [1:0] dir_q, dir_d;
  logic [7:0] goal, gap, delta;

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    goal   = target;
    gap    = '0;
    delta  = '0;
    if (clear) begin
      duty_d = '0;
      dir_d  = DIR_COAST;
    end else if (tick) begin
      // A pending reversal first drains duty; the flip happens on the zero tick.
      if ((dir_q != req_dir) && (duty_q != 8'd0)) goal = 8'd0;
      else                                        dir_d = req_dir;
      gap    = (goal > duty_q) ? (goal - duty_q) : (duty_q - goal);
      delta  = (gap > STEP) ? STEP : gap;
      duty_d = (goal > duty_q) ? (duty_q + delta) : (duty_q - delta);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      dir_q  <= DIR_COAST;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
    end
  end

  assign duty      = duty_q;
  assign dir       = dir_q;
  assign at_target = (duty_q == target) && (dir_q == req_dir);

endmodule

`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
//------------------------------------------------------------------
// motor_cmd_sequencer : command decode, steer pulse, ramped drive, watchdog
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int RAMP_DIV   = 100000,
  parameter int RAMP_STEP  = 8,
  parameter int WDT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        estop,
  output logic        steer_stby,
  output logic        drive_stby,
  output logic [1:0]  steer_dir,
  output logic [7:0]  steer_duty,
  output logic [20:0] steer_time,
  output logic        steer_trigger,
  output logic [1:0]  drive_dir_a,
  output logic [1:0]  drive_dir_b,
  output logic [7:0]  drive_duty_a,
  output logic [7:0]  drive_duty_b,
  output logic        steer_busy,
  output logic        ramping,
  output logic        wdt_expired
);

  localparam int BUSY_W = STEER_TIME_W + STEER_UNIT_LOG2;

  seq_state_e               state_q, state_d;
  logic                     run_q;
  logic [BUSY_W-1:0]        busy_cnt_q, busy_cnt_d;
  logic [31:0]              tick_cnt_q, tick_cnt_d;
  logic [31:0]              wdt_cnt_q, wdt_cnt_d;
  logic                     wdt_expired_q, wdt_expired_d;
  logic [7:0]               tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d;
  logic [1:0]               req_dir_a_q, req_dir_a_d, req_dir_b_q, req_dir_b_d;
  logic                     drive_stby_q, drive_stby_d, steer_stby_q, steer_stby_d;
  logic [1:0]               steer_dir_q, steer_dir_d;
  logic [7:0]               steer_duty_q, steer_duty_d;
  logic [STEER_TIME_W-1:0]  steer_time_q, steer_time_d;
  logic                     steer_trigger_q, steer_trigger_d;

  opcode_e op;
  logic    tick, accept, stop_cmd, stop_now, wdt_trip;
  logic    at_a, at_b;

  assign op        = opcode_e'(cmd_data[31:30]);
  assign tick      = (tick_cnt_q == 32'(RAMP_DIV - 1));
  assign cmd_ready = run_q && (state_q == ST_IDLE) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  // STOP is also taken while busy so the host can abort a steering pulse.
  assign stop_cmd  = cmd_valid && run_q && !estop && (op == OP_STOP);
  assign stop_now  = estop || stop_cmd;
  assign wdt_trip  = !accept && !stop_cmd && (wdt_cnt_q == 32'(WDT_CYCLES - 1));

  always_comb begin
    state_d         = state_q;
    busy_cnt_d      = busy_cnt_q;
    tick_cnt_d      = tick ? 32'd0 : tick_cnt_q + 32'd1;
    wdt_cnt_d       = wdt_cnt_q;
    wdt_expired_d   = wdt_expired_q;
    tgt_a_d         = tgt_a_q;
    tgt_b_d         = tgt_b_q;
    req_dir_a_d     = req_dir_a_q;
    req_dir_b_d     = req_dir_b_q;
    drive_stby_d    = drive_stby_q;
    steer_stby_d    = steer_stby_q;
    steer_dir_d     = steer_dir_q;
    steer_duty_d    = steer_duty_q;
    steer_time_d    = steer_time_q;
    steer_trigger_d = 1'b0;

    if (accept || stop_cmd)              wdt_cnt_d = '0;
    else if (wdt_cnt_q != 32'(WDT_CYCLES)) wdt_cnt_d = wdt_cnt_q + 32'd1;

    if (wdt_trip) begin
      wdt_expired_d = 1'b1;
      tgt_a_d       = '0;
      tgt_b_d       = '0;
    end

    if (state_q == ST_STEER_BUSY) begin
      if (busy_cnt_q >= {steer_time_q, {STEER_UNIT_LOG2{1'b0}}}) state_d = ST_IDLE;
      else                                                        busy_cnt_d = busy_cnt_q + 1'b1;
    end

    if (accept) begin
      case (op)
        OP_KEEPALIVE: wdt_expired_d = 1'b0;
        OP_DRIVE: begin
          req_dir_a_d   = cmd_data[29:28];
          req_dir_b_d   = cmd_data[27:26];
          tgt_a_d       = cmd_data[15:8];
          tgt_b_d       = cmd_data[7:0];
          drive_stby_d  = 1'b1;
          wdt_expired_d = 1'b0;
        end
        OP_STEER: begin
          steer_dir_d     = cmd_data[29:28];
          steer_duty_d    = cmd_data[27:20];
          steer_time_d    = {1'b0, cmd_data[19:0]};
          steer_stby_d    = 1'b1;
          steer_trigger_d = 1'b1;
          wdt_expired_d   = 1'b0;
          busy_cnt_d      = {{(BUSY_W-1){1'b0}}, 1'b1};
          state_d         = (cmd_data[19:0] == 20'd0) ? ST_IDLE : ST_STEER_BUSY;
        end
        OP_STOP: ;
        default: ;
      endcase
    end

    if (stop_now) begin
      tgt_a_d         = '0;
      tgt_b_d         = '0;
      req_dir_a_d     = DIR_COAST;
      req_dir_b_d     = DIR_COAST;
      drive_stby_d    = 1'b0;
      steer_stby_d    = 1'b0;
      steer_dir_d     = DIR_COAST;
      steer_trigger_d = 1'b0;
      state_d         = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      run_q           <= 1'b0;
      busy_cnt_q      <= '0;
      tick_cnt_q      <= '0;
      wdt_cnt_q       <= '0;
      wdt_expired_q   <= 1'b0;
      tgt_a_q         <= '0;
      tgt_b_q         <= '0;
      req_dir_a_q     <= DIR_COAST;
      req_dir_b_q     <= DIR_COAST;
      drive_stby_q    <= 1'b0;
      steer_stby_q    <= 1'b0;
      steer_dir_q     <= DIR_COAST;
      steer_duty_q    <= '0;
      steer_time_q    <= '0;
      steer_trigger_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      busy_cnt_q      <= busy_cnt_d;
      tick_cnt_q      <= tick_cnt_d;
      wdt_cnt_q       <= wdt_cnt_d;
      wdt_expired_q   <= wdt_expired_d;
      tgt_a_q         <= tgt_a_d;
      tgt_b_q         <= tgt_b_d;
      req_dir_a_q     <= req_dir_a_d;
      req_dir_b_q     <= req_dir_b_d;
      drive_stby_q    <= drive_stby_d;
      steer_stby_q    <= steer_stby_d;
      steer_dir_q     <= steer_dir_d;
      steer_duty_q    <= steer_duty_d;
      steer_time_q    <= steer_time_d;
      steer_trigger_q <= steer_trigger_d;
    end
  end

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(stop_now),
    .target(tgt_a_q), .req_dir(req_dir_a_q),
    .duty(drive_duty_a), .dir(drive_dir_a), .at_target(at_a)
  );

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(stop_now),
    .target(tgt_b_q), .req_dir(req_dir_b_q),
    .duty(drive_duty_b), .dir(drive_dir_b), .at_target(at_b)
  );

  assign steer_busy    = (state_q == ST_STEER_BUSY);
  assign ramping       = !(at_a && at_b);
  assign wdt_expired   = wdt_expired_q;
  assign drive_stby    = drive_stby_q;
  assign steer_stby    = steer_stby_q;
  assign steer_dir     = steer_dir_q;
  assign steer_duty    = steer_duty_q;
  assign steer_time    = steer_time_q;
  assign steer_trigger = steer_trigger_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
//------------------------------------------------------------------
// tb_motor_cmd_sequencer : directed self-checking bench
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_motor_cmd_sequencer;

  localparam int RDIV = 4;

  logic        clk, rst_n;
  logic        cmd_valid, estop, cmd_valid2, estop2;
  logic [31:0] cmd_data, cmd_data2;
  logic        cmd_ready, steer_stby, drive_stby, steer_trigger, steer_busy, ramping, wdt_expired;
  logic [1:0]  steer_dir, dir_a, dir_b;
  logic [7:0]  steer_duty, duty_a, duty_b;
  logic [20:0] steer_time;
  logic        cmd_ready2, steer_stby2, drive_stby2, steer_trigger2, steer_busy2, ramping2, wdt_expired2;
  logic [1:0]  steer_dir2, dir_a2, dir_b2;
  logic [7:0]  steer_duty2, duty_a2, duty_b2;
  logic [20:0] steer_time2;

  int n_checks = 0;
  int n_fail   = 0;

  motor_cmd_sequencer #(.RAMP_DIV(RDIV), .RAMP_STEP(8), .WDT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .estop(estop), .steer_stby(steer_stby), .drive_stby(drive_stby),
    .steer_dir(steer_dir), .steer_duty(steer_duty), .steer_time(steer_time),
    .steer_trigger(steer_trigger), .drive_dir_a(dir_a), .drive_dir_b(dir_b),
    .drive_duty_a(duty_a), .drive_duty_b(duty_b), .steer_busy(steer_busy),
    .ramping(ramping), .wdt_expired(wdt_expired)
  );

  motor_cmd_sequencer #(.RAMP_DIV(RDIV), .RAMP_STEP(100), .WDT_CYCLES(1000000)) dut100 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_data(cmd_data2),
    .cmd_ready(cmd_ready2), .estop(estop2), .steer_stby(steer_stby2), .drive_stby(drive_stby2),
    .steer_dir(steer_dir2), .steer_duty(steer_duty2), .steer_time(steer_time2),
    .steer_trigger(steer_trigger2), .drive_dir_a(dir_a2), .drive_dir_b(dir_b2),
    .drive_duty_a(duty_a2), .drive_duty_b(duty_b2), .steer_busy(steer_busy2),
    .ramping(ramping2), .wdt_expired(wdt_expired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one command at a negedge, hold until accepted (bounded), return #1 after the accepting edge.
  task automatic send(input bit sel, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin cmd_valid2 = 1'b1; cmd_data2 = d; end
    else     begin cmd_valid  = 1'b1; cmd_data  = d; end
    #1;
    while (!(sel ? cmd_ready2 : cmd_ready) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("send_ready", {31'd0, (sel ? cmd_ready2 : cmd_ready)}, 32'd1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  task automatic wait_change(input bit sel, input logic [7:0] prev, output logic [7:0] now);
    now = prev;
    for (int i = 0; i < 4 * RDIV && now == prev; i++) begin
      @(negedge clk);
      now = sel ? duty_a2 : duty_a;
    end
  endtask

  logic [7:0] v;
  logic [7:0] rev_duty [7];
  logic [1:0] rev_dir  [7];
  int         cnt;

  initial begin
    rev_duty = '{8'd32, 8'd24, 8'd16, 8'd8, 8'd0, 8'd8, 8'd16};
    rev_dir  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    rst_n = 1'b0; estop = 1'b0; estop2 = 1'b0;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_data = '0; cmd_data2 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst_duty_a", {24'd0, duty_a}, 0);
    check("rst_steer_busy", {31'd0, steer_busy}, 0);
    check("rst_wdt", {31'd0, wdt_expired}, 0);
    check("rst_drive_stby", {31'd0, drive_stby}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 1);

    // DRIVE A forward to 40, step 8
    send(0, {2'b01, 2'b10, 2'b00, 10'd0, 8'd40, 8'd0});
    @(negedge clk);
    check("drive_stby_set", {31'd0, drive_stby}, 1);
    check("ramping_start", {31'd0, ramping}, 1);
    v = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      wait_change(0, v, v);
      check("ramp_up_a", {24'd0, v}, 32'(8 * k));
      check("ramp_up_dir", {30'd0, dir_a}, 2);
    end
    check("ramping_done", {31'd0, ramping}, 0);

    // Reverse to backward 16 through zero
    send(0, {2'b01, 2'b01, 2'b00, 10'd0, 8'd16, 8'd0});
    for (int k = 0; k < 7; k++) begin
      wait_change(0, v, v);
      check("rev_duty", {24'd0, v}, {24'd0, rev_duty[k]});
      check("rev_dir", {30'd0, dir_a}, {30'd0, rev_dir[k]});
    end

    // STEER left, duty 200, time 3 -> 384 busy cycles
    send(0, {2'b10, 2'b10, 8'd200, 20'd3});
    @(negedge clk);
    check("steer_trigger", {31'd0, steer_trigger}, 1);
    check("steer_busy_rise", {31'd0, steer_busy}, 1);
    check("steer_ready_low", {31'd0, cmd_ready}, 0);
    check("steer_dir", {30'd0, steer_dir}, 2);
    check("steer_duty", {24'd0, steer_duty}, 200);
    check("steer_time", {11'd0, steer_time}, 3);
    check("steer_stby", {31'd0, steer_stby}, 1);
    cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) check("steer_trigger_1cyc", {31'd0, steer_trigger}, 0);
      if (!steer_busy) break;
      cnt++;
    end
    check("steer_busy_len", cnt, 384);
    check("steer_ready_back", {31'd0, cmd_ready}, 1);

    // Estop aborts a steering pulse
    send(0, {2'b10, 2'b01, 8'd50, 20'd5});
    repeat (20) @(negedge clk);
    check("abort_busy_before", {31'd0, steer_busy}, 1);
    check("abort_duty_before", {24'd0, duty_a}, 16);
    estop = 1'b1;
    #1;
    check("estop_ready_low", {31'd0, cmd_ready}, 0);
    @(posedge clk); #1;
    estop = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, steer_busy}, 0);
    check("abort_ready", {31'd0, cmd_ready}, 1);
    check("abort_duty_a", {24'd0, duty_a}, 0);
    check("abort_dir_a", {30'd0, dir_a}, 0);
    check("abort_drive_stby", {31'd0, drive_stby}, 0);
    check("abort_steer_stby", {31'd0, steer_stby}, 0);

    // Estop has priority over a valid DRIVE
    estop = 1'b1; cmd_valid = 1'b1; cmd_data = {2'b01, 2'b10, 2'b00, 10'd0, 8'd40, 8'd0};
    #1;
    check("estop_prio_ready", {31'd0, cmd_ready}, 0);
    @(posedge clk); #1;
    estop = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("estop_prio_stby", {31'd0, drive_stby}, 0);
    check("estop_prio_ramping", {31'd0, ramping}, 0);

    // STEER with time 0 pulses but never goes busy
    send(0, {2'b10, 2'b01, 8'd10, 20'd0});
    @(negedge clk);
    check("t0_trigger", {31'd0, steer_trigger}, 1);
    check("t0_busy", {31'd0, steer_busy}, 0);
    check("t0_ready", {31'd0, cmd_ready}, 1);

    // Watchdog trips 1000 cycles after the last command
    send(0, {2'b01, 2'b10, 2'b10, 10'd0, 8'd64, 8'd64});
    repeat (1000) @(negedge clk);
    check("wdt_pre_duty", {24'd0, duty_a}, 64);
    check("wdt_pre_flag", {31'd0, wdt_expired}, 0);
    @(negedge clk);
    check("wdt_trip_flag", {31'd0, wdt_expired}, 1);
    wait_change(0, 8'd64, v);
    check("wdt_ramp_down", {24'd0, v}, 56);
    for (int i = 0; i < 20 * RDIV && duty_a != 8'd0; i++) @(negedge clk);
    check("wdt_duty_a_zero", {24'd0, duty_a}, 0);
    check("wdt_duty_b_zero", {24'd0, duty_b}, 0);
    check("wdt_dir_kept", {30'd0, dir_a}, 2);
    check("wdt_stby_kept", {31'd0, drive_stby}, 1);
    send(0, 32'h0000_0000);
    @(negedge clk);
    check("wdt_keepalive_clr", {31'd0, wdt_expired}, 0);

    // Large step saturates at 255 without wrapping, then STOP zeroes at once
    send(1, {2'b01, 2'b10, 2'b00, 10'd0, 8'd255, 8'd0});
    v = 8'd0;
    wait_change(1, v, v); check("big_step_1", {24'd0, v}, 100);
    wait_change(1, v, v); check("big_step_2", {24'd0, v}, 200);
    wait_change(1, v, v); check("big_step_3", {24'd0, v}, 255);
    check("big_ramping_done", {31'd0, ramping2}, 0);
    repeat (2 * RDIV) @(negedge clk);
    check("big_hold", {24'd0, duty_a2}, 255);
    send(1, 32'hC000_0000);
    @(negedge clk);
    check("stop_duty", {24'd0, duty_a2}, 0);
    check("stop_dir", {30'd0, dir_a2}, 0);
    check("stop_stby", {31'd0, drive_stby2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
